// File: rtl/r_type_exu.sv
// r_type_exu: registered R-type execute unit with valid/ready on both sides.
// Define RV_M_EXT_EN to build the M-extension multiplier and divider.
module r_type_exu #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_funct7,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic [RD_W-1:0] out_rd_q, out_rd_d;
  logic            out_ill_q, out_ill_d;

  logic            accept;
  logic            is_m;
  logic [XLEN-1:0] base_res;
  logic            base_legal;
  logic [SHW-1:0]  shamt;

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_ill_q;

  // HOLD may hand its result over and take a new op in the same cycle
  assign in_ready = ((state_q == S_IDLE) || (state_q == S_HOLD)) &&
                    (!out_valid_q || out_ready);

  // flush kills a same-cycle accept
  assign accept = in_valid && in_ready && !flush;
  assign shamt  = in_rs2[SHW-1:0];

`ifdef RV_M_EXT_EN
  assign is_m = (in_funct7 == 7'h01);
`else
  assign is_m = 1'b0;
`endif

  // base RV32I/RV64I R-type decode and single-cycle result
  always_comb begin
    base_res   = '0;
    base_legal = 1'b0;
    unique case (in_funct3)
      3'd0: begin
        base_legal = (in_funct7 == 7'h00) || (in_funct7 == 7'h20);
        base_res   = (in_funct7 == 7'h20) ? in_rs1 - in_rs2
                                          : in_rs1 + in_rs2;
      end
      3'd1: begin
        base_legal = (in_funct7 == 7'h00);
        base_res   = in_rs1 << shamt;
      end
      3'd2: begin
        base_legal = (in_funct7 == 7'h00);
        base_res   = {{(XLEN-1){1'b0}},
                      $signed(in_rs1) < $signed(in_rs2)};
      end
      3'd3: begin
        base_legal = (in_funct7 == 7'h00);
        base_res   = {{(XLEN-1){1'b0}}, in_rs1 < in_rs2};
      end
      3'd4: begin
        base_legal = (in_funct7 == 7'h00);
        base_res   = in_rs1 ^ in_rs2;
      end
      3'd5: begin
        base_legal = (in_funct7 == 7'h00) || (in_funct7 == 7'h20);
        base_res   = (in_funct7 == 7'h20)
                   ? XLEN'($signed(in_rs1) >>> shamt)
                   : in_rs1 >> shamt;
      end
      3'd6: begin
        base_legal = (in_funct7 == 7'h00);
        base_res   = in_rs1 | in_rs2;
      end
      3'd7: begin
        base_legal = (in_funct7 == 7'h00);
        base_res   = in_rs1 & in_rs2;
      end
    endcase
  end

`ifdef RV_M_EXT_EN
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [1:0]      f3_q, f3_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;

  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     rem_sh, diff;
  logic              step_ge;
  logic [XLEN-1:0]   quo_n, rem_n, div_res;
  logic              a_neg, b_neg;

  // multiply from latched operands; MUL/MULH/MULHSU/MULHU by f3[1:0]
  always_comb begin
    mul_a = {{XLEN{(f3_q != 2'd3) & op_a_q[XLEN-1]}}, op_a_q};
    mul_b = {{XLEN{(f3_q == 2'd1) & op_b_q[XLEN-1]}}, op_b_q};
    prod  = mul_a * mul_b;
    mul_res = (f3_q == 2'd0) ? prod[XLEN-1:0]
                             : prod[2*XLEN-1:XLEN];
  end

  // one restoring-division step plus final sign fix-up
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    step_ge = !diff[XLEN];
    quo_n   = {quo_q[XLEN-2:0], step_ge};
    rem_n   = step_ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    if (dz_q)
      div_res = f3_q[1] ? op_a_q : '1;
    else if (f3_q[1])
      div_res = rneg_q ? -rem_n : rem_n;
    else
      div_res = qneg_q ? -quo_n : quo_n;
  end

  // operand signs of an incoming signed divide
  always_comb begin
    a_neg = !in_funct3[0] && in_rs1[XLEN-1];
    b_neg = !in_funct3[0] && in_rs2[XLEN-1];
  end
`endif

  // next-state, output register and M-unit operand control
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_ill_d   = out_ill_q;
`ifdef RV_M_EXT_EN
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    f3_d   = f3_q;
    rd_d   = rd_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
`endif
    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if (!out_valid_q || out_ready)
          state_d = S_IDLE;
        if (accept && !is_m) begin
          out_valid_d = 1'b1;
          out_data_d  = base_legal ? base_res : '0;
          out_ill_d   = !base_legal;
          out_rd_d    = in_rd;
        end
`ifdef RV_M_EXT_EN
        if (accept && is_m) begin
          op_a_d = in_rs1;
          op_b_d = in_rs2;
          f3_d   = in_funct3[1:0];
          rd_d   = in_rd;
          if (!in_funct3[2]) begin
            state_d = S_MUL;
          end else begin
            state_d = S_DIV;
            quo_d   = a_neg ? -in_rs1 : in_rs1;
            dvs_d   = b_neg ? -in_rs2 : in_rs2;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = (in_rs2 == '0);
          end
        end
`endif
      end
      S_MUL: begin
`ifdef RV_M_EXT_EN
        out_valid_d = 1'b1;
        out_data_d  = mul_res;
        out_ill_d   = 1'b0;
        out_rd_d    = rd_q;
        state_d     = S_HOLD;
`else
        state_d = S_IDLE;
`endif
      end
      S_DIV: begin
`ifdef RV_M_EXT_EN
        quo_d = quo_n;
        rem_d = rem_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN-1)) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = div_res;
          out_ill_d   = 1'b0;
          out_rd_d    = rd_q;
          state_d     = S_HOLD;
        end
`else
        state_d = S_IDLE;
`endif
      end
    endcase
    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
`ifdef RV_M_EXT_EN
      cnt_d = '0;
`endif
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_ill_q   <= out_ill_d;
    end
  end

`ifdef RV_M_EXT_EN
  // multiplier/divider operand and iteration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
      f3_q   <= '0;
      rd_q   <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      f3_q   <= f3_d;
      rd_q   <= rd_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end
`endif

endmodule
